rvv_backend_mac_sched: RTL and testbench
========================================

Name: rvv_backend_mac_sched

Overview:
- Scheduler between the MUL reservation-station FIFO, two MAC lanes, and the two ROB write ports.
- Pops up to two uops per cycle and assigns each to a MAC lane round-robin, using per-lane credits.
- Records issue order in an order FIFO and retires lane results to the ROB strictly in program order.
- Sits inside the mul/mac wrapper, replacing the fixed uop0→lane0 / uop1→lane1 binding.

Parameters:
- NUM_LANE, 2, number of MAC lanes and ROB ports (fixed at 2).
- LANE_CREDITS, 3, maximum uops in flight per lane (pipeline depth plus output register).
- ORD_DEPTH, 8, order FIFO entries; must be ≥ NUM_LANE*LANE_CREDITS and a power of 2.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous active-high reset.
- trap_flush_rvv  input  1  synchronous flush of all in-flight state.
- rs_fifo_empty  input  1  RS FIFO holds 0 uops.
- rs_fifo_1left_to_empty  input  1  RS FIFO holds exactly 1 uop.
- ex2rs_fifo_pop  output  2  pop[0] = head uop taken; pop[1] = second uop taken.
- lane_issue_vld  output  2  per-lane issue strobe.
- lane_issue_src  output  2  per lane, which RS slot (0/1) drives the lane's uop input.
- lane_res_vld  input  2  lane has a result at its output.
- lane_res_ack  output  2  lane result consumed this cycle.
- rob_vld  output  2  ROB write-port valid.
- rob_lane_sel  output  2  per ROB port, which lane's result to mux onto it.
- rob_ready  input  2  ROB port ready.
- inflight_cnt  output  $clog2(ORD_DEPTH+1)  occupancy of the order FIFO (debug/perf).

Behaviour:
- Reset (rst high, asynchronous):
  - credits = LANE_CREDITS per lane; order FIFO empty, wr/rd pointers 0; rr pointer = 0.
  - All outputs 0, including inflight_cnt.
- Availability:
  - avail0 = !rs_fifo_empty.
  - avail1 = !rs_fifo_empty && !rs_fifo_1left_to_empty.
- Issue slot 0:
  - Condition: avail0 && !flush && some lane has credit > 0 && FIFO free ≥ 1.
  - Target lane: rr if its credit > 0, else the other lane.
- Issue slot 1:
  - Condition: slot 0 issues && avail1 && the other lane (not slot 0's) has credit > 0 && FIFO free ≥ 2.
  - pop[1] never asserts without pop[0].
- Issue outputs:
  - lane_issue_vld[l] and lane_issue_src[l] are combinational from the conditions above.
  - ex2rs_fifo_pop = issued slots.
- Round-robin pointer: rr toggles when exactly one uop issues; unchanged when 0 or 2 issue.
- Order FIFO: on issue, push target lane ids, slot 0 first, then slot 1 (0, 1 or 2 pushes per cycle).
- Retire port 0:
  - h0 = lane id at FIFO head.
  - rob_vld[0] = FIFO non-empty && lane_res_vld[h0] && !flush; rob_lane_sel[0] = h0.
- Retire port 1:
  - h1 = entry at head+1.
  - rob_vld[1] = port 0 fires (rob_vld[0] && rob_ready[0]) && occupancy ≥ 2 && h1 ≠ h0 && lane_res_vld[h1] && !flush.
  - When h1 == h0, only one retire is allowed that cycle, because a lane presents one result per cycle.
- Retire fire: port p fires when rob_vld[p] && rob_ready[p]. On fire:
  - lane_res_ack[lane] = 1;
  - pop the FIFO;
  - credit[lane] += 1.
- Port ordering: port 1 never fires without port 0. Results always reach the ROB in issue order; a lane with a ready result but not at the head stalls (no ack).
- Same-cycle credit update: credit_next = credit − issued_to_lane + retired_from_lane. Saturation never occurs; SVA asserts 0 ≤ credit ≤ LANE_CREDITS.
- Same-cycle FIFO update: up to 2 pushes and 2 pops. Occupancy_next = occ + pushes − pops, using the current-cycle free count (no bypass of same-cycle pops into issue eligibility).
- Flush (trap_flush_rvv high):
  - Same cycle: pop, issue, rob_vld and ack are forced to 0.
  - Next cycle: credits full, FIFO empty, rr = 0. Lanes flush their own pipelines.
- Pointer wrap: pointers are $clog2(ORD_DEPTH) bits and wrap modulo ORD_DEPTH. Occupancy is tracked by a separate counter (full = ORD_DEPTH).
- Latency:
  - Issue is combinational; no extra cycle from RS head to lane.
  - Retire is combinational from lane_res_vld; no added cycle.

Decomposition:
- rvv_backend.svh already carries NUM_MUL; add to it:
  - the lane-id typedef;
  - MAC_LANE_CREDITS;
  - MAC_ORD_DEPTH.
- One natural sub-module: rvv_backend_mac_ord_fifo, a 2-write/2-read lane-id FIFO exposing head, head+1, occupancy and flush.
- Credits, rr and the issue/retire combinational logic stay in the top module.

Test Plan:
- Single uop (empty=0, 1left=1), rr=0, all credits 3 → pop=01, lane_issue_vld=01; next cycle rr=1, inflight_cnt=1.
- Two uops every cycle, lanes return results in 2 cycles, rob_ready=11 → steady pop=11 and rob_vld=11; ROB receives lane order 0,1,0,1…; credits never below 1.
- Lane 1 result arrives before lane 0 for the older uop → lane_res_ack[1] held 0 and rob_vld=00 until lane 0 is valid; then rob_lane_sel={1,0} and both fire the same cycle.
- rob_ready=00 for 6 cycles under continuous issue → lane 0 issues stop after 3 in flight and lane 1 after 3 (pops stop at credits 0, inflight_cnt=6); then rob_ready=11 drains in order.
- FIFO head and head+1 both lane 0 (forced by lane 1 credit exhaustion) → only rob_vld[0] asserts per cycle.
- trap_flush_rvv pulse with 5 in flight → outputs 0 that cycle; next cycle inflight_cnt=0, credits 3/3, rr=0; rst asserted mid-burst gives the same result asynchronously.

Source files
------------

// File: rtl/rvv_backend_mac_sched_pkg.sv
// Shared types and sizing for the MAC lane scheduler and its order FIFO.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package rvv_backend_mac_sched_pkg;

  // Number of MAC lanes and ROB write ports; the scheduler logic assumes two.
  localparam int MAC_NUM_LANE     = 2;
  // Uops one lane may hold in flight: pipeline depth plus output register.
  localparam int MAC_LANE_CREDITS = 3;
  // Order FIFO entries; power of 2 and at least MAC_NUM_LANE*MAC_LANE_CREDITS.
  localparam int MAC_ORD_DEPTH    = 8;

  // Identifies one MAC lane.
  typedef logic [0:0] lane_id_t;

  // With two lanes, the "other" lane is the complement.
  function automatic lane_id_t other_lane(lane_id_t l);
    return ~l;
  endfunction

endpackage

// File: rtl/rvv_backend_mac_sched_if.sv
// RS-FIFO / MAC-lane / ROB-port bundle seen by the MAC scheduler.
// Latency: wires only.
// Backpressure: the RS FIFO fill level and rob_ready are inputs to the scheduler; pops and acks are its outputs.
interface rvv_backend_mac_sched_if
  import rvv_backend_mac_sched_pkg::*;
#(
  parameter int ORD_DEPTH = MAC_ORD_DEPTH
) ();

  // RS FIFO side
  logic                             rs_fifo_empty;
  logic                             rs_fifo_1left_to_empty;
  logic [1:0]                       ex2rs_fifo_pop;
  // MAC lane side
  logic [1:0]                       lane_issue_vld;
  logic [1:0]                       lane_issue_src;
  logic [1:0]                       lane_res_vld;
  logic [1:0]                       lane_res_ack;
  // ROB side
  logic [1:0]                       rob_vld;
  logic [1:0]                       rob_lane_sel;
  logic [1:0]                       rob_ready;
  // Debug / perf
  logic [$clog2(ORD_DEPTH+1)-1:0]   inflight_cnt;

  // Scheduler view
  modport master (
    input  rs_fifo_empty, rs_fifo_1left_to_empty, lane_res_vld, rob_ready,
    output ex2rs_fifo_pop, lane_issue_vld, lane_issue_src, lane_res_ack,
           rob_vld, rob_lane_sel, inflight_cnt
  );

  // Surrounding wrapper view
  modport slave (
    output rs_fifo_empty, rs_fifo_1left_to_empty, lane_res_vld, rob_ready,
    input  ex2rs_fifo_pop, lane_issue_vld, lane_issue_src, lane_res_ack,
           rob_vld, rob_lane_sel, inflight_cnt
  );

endinterface

// File: rtl/rvv_backend_mac_ord_fifo.sv
// 2-write/2-read FIFO of lane ids recording MAC issue order; exposes head, head+1 and occupancy.
// Latency: pushes become visible at head one cycle later; head/head+1 are read straight from storage.
// Backpressure: none internally; the caller must not push beyond free space or pop beyond occupancy.
module rvv_backend_mac_ord_fifo
  import rvv_backend_mac_sched_pkg::*;
#(
  parameter int DEPTH = MAC_ORD_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic [1:0]                   push_vld,   // push_vld[1] only together with push_vld[0]
  input  lane_id_t                     push_dat0,
  input  lane_id_t                     push_dat1,
  input  logic [1:0]                   pop_cnt,    // 0, 1 or 2 entries
  output lane_id_t                     head_dat,
  output lane_id_t                     head1_dat,
  output logic [$clog2(DEPTH+1)-1:0]   occ
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH+1);

  lane_id_t          mem_q [DEPTH];
  lane_id_t          mem_d [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]     occ_q, occ_d;
  logic [PW-1:0]     wr_ptr_p1;
  logic [PW-1:0]     rd_ptr_p1;
  logic [1:0]        push_cnt;

  // Next storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
  always_comb begin
    mem_d     = mem_q;
    wr_ptr_p1 = wr_ptr_q + PW'(1);
    push_cnt  = {1'b0, push_vld[0]} + {1'b0, push_vld[1]};
    if (push_vld[0]) mem_d[wr_ptr_q]  = push_dat0;
    if (push_vld[1]) mem_d[wr_ptr_p1] = push_dat1;
    wr_ptr_d  = wr_ptr_q + PW'(push_cnt);
    rd_ptr_d  = rd_ptr_q + PW'(pop_cnt);
    occ_d     = occ_q + OW'(push_cnt) - OW'(pop_cnt);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Read ports: oldest entry and the one behind it.
  always_comb begin
    rd_ptr_p1 = rd_ptr_q + PW'(1);
    head_dat  = mem_q[rd_ptr_q];
    head1_dat = mem_q[rd_ptr_p1];
    occ       = occ_q;
  end

  a_no_overflow:  assert property (@(posedge clk) disable iff (rst) occ_q <= OW'(DEPTH));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst) OW'(pop_cnt) <= occ_q);

endmodule

// File: rtl/rvv_backend_mac_sched.sv
// Pops up to two MUL uops per cycle onto two MAC lanes round-robin under per-lane credits; retires results in program order.
// Latency: issue and retire are both combinational (RS head to lane, lane result to ROB, same cycle).
// Backpressure: issue stalls on lane credits or order-FIFO space; retire stalls on rob_ready or a non-head lane result.
module rvv_backend_mac_sched
  import rvv_backend_mac_sched_pkg::*;
#(
  parameter int NUM_LANE     = MAC_NUM_LANE,
  parameter int LANE_CREDITS = MAC_LANE_CREDITS,
  parameter int ORD_DEPTH    = MAC_ORD_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        trap_flush_rvv,
  rvv_backend_mac_sched_if.master     io
);

  localparam int CW = $clog2(LANE_CREDITS+1);
  localparam int OW = $clog2(ORD_DEPTH+1);

  logic [CW-1:0]  credit_q [NUM_LANE];
  logic [CW-1:0]  credit_d [NUM_LANE];
  lane_id_t       rr_q, rr_d;

  // Reset also masks the combinational outputs so the block is fully quiet while held.
  logic           kill;
  logic           avail0, avail1;
  logic [OW-1:0]  occ, free;
  logic           iss0, iss1;
  lane_id_t       tgt0, tgt1;
  lane_id_t       h0, h1;
  logic           rv0, rv1, fire0, fire1;
  logic [1:0]     pop_cnt;

  assign kill = trap_flush_rvv | rst;

  // Issue decision: slot 0 goes to rr (or the other lane if rr is out of credit), slot 1 to the remaining lane.
  always_comb begin
    free   = OW'(ORD_DEPTH) - occ;
    avail0 = !io.rs_fifo_empty;
    avail1 = !io.rs_fifo_empty && !io.rs_fifo_1left_to_empty;
    tgt0   = (credit_q[rr_q] != '0) ? rr_q : other_lane(rr_q);
    tgt1   = other_lane(tgt0);
    iss0   = avail0 && !kill && ((credit_q[0] != '0) || (credit_q[1] != '0)) && (free >= OW'(1));
    iss1   = iss0 && avail1 && (credit_q[tgt1] != '0) && (free >= OW'(2));
    io.lane_issue_vld = '0;
    io.lane_issue_src = '0;
    if (iss0) io.lane_issue_vld[tgt0] = 1'b1;
    if (iss1) begin
      io.lane_issue_vld[tgt1] = 1'b1;
      io.lane_issue_src[tgt1] = 1'b1;
    end
    io.ex2rs_fifo_pop = {iss1, iss0};
  end

  // Retire decision: port 0 takes the head lane; port 1 the next entry only if it is a different lane.
  always_comb begin
    rv0   = (occ != '0) && io.lane_res_vld[h0] && !kill;
    fire0 = rv0 && io.rob_ready[0];
    rv1   = fire0 && (occ >= OW'(2)) && (h1 != h0) && io.lane_res_vld[h1] && !kill;
    fire1 = rv1 && io.rob_ready[1];
    io.rob_vld      = {rv1, rv0};
    io.rob_lane_sel = {rv1 & h1[0], rv0 & h0[0]};
    io.lane_res_ack = '0;
    if (fire0) io.lane_res_ack[h0] = 1'b1;
    if (fire1) io.lane_res_ack[h1] = 1'b1;
    pop_cnt = {1'b0, fire0} + {1'b0, fire1};
  end

  // Credit and round-robin next state: each lane sees at most one issue and one retire per cycle.
  always_comb begin
    for (int l = 0; l < NUM_LANE; l++) begin
      credit_d[l] = credit_q[l] - CW'(io.lane_issue_vld[l]) + CW'(io.lane_res_ack[l]);
    end
    rr_d = (iss0 ^ iss1) ? other_lane(rr_q) : rr_q;
    if (trap_flush_rvv) begin
      for (int l = 0; l < NUM_LANE; l++) credit_d[l] = CW'(LANE_CREDITS);
      rr_d = '0;
    end
  end

  // Credit and round-robin registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int l = 0; l < NUM_LANE; l++) credit_q[l] <= CW'(LANE_CREDITS);
      rr_q <= '0;
    end else begin
      credit_q <= credit_d;
      rr_q     <= rr_d;
    end
  end

  rvv_backend_mac_ord_fifo #(
    .DEPTH     (ORD_DEPTH)
  ) u_ord_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (trap_flush_rvv),
    .push_vld  ({iss1, iss0}),
    .push_dat0 (tgt0),
    .push_dat1 (tgt1),
    .pop_cnt   (pop_cnt),
    .head_dat  (h0),
    .head1_dat (h1),
    .occ       (occ)
  );

  assign io.inflight_cnt = occ;

  for (genvar g = 0; g < NUM_LANE; g++) begin : g_credit_chk
    a_credit_range: assert property (@(posedge clk) disable iff (rst) credit_q[g] <= CW'(LANE_CREDITS));
  end

endmodule

// File: tb/tb_rvv_backend_mac_sched.sv
// Randomized and directed bench for the MAC scheduler against a queue-based reference model.
// Latency: lane results return 1..lat_max cycles after issue in the bench's lane model.
// Backpressure: RS fill level, rob_ready and lane result gating are randomized per phase.
module tb_rvv_backend_mac_sched;
  import rvv_backend_mac_sched_pkg::*;

  localparam int LC = MAC_LANE_CREDITS;
  localparam int OD = MAC_ORD_DEPTH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;

  rvv_backend_mac_sched_if io ();

  rvv_backend_mac_sched dut (
    .clk            (clk),
    .rst            (rst),
    .trap_flush_rvv (flush),
    .io             (io)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: credits per lane, rr pointer, issue-order queue, per-lane result queues.
  int m_credit [2];
  int m_rr;
  int m_ord [$];
  int lq0 [$];
  int lq1 [$];
  int cyc = 0;
  bit gate [2];
  int lat_max = 2;
  int p_empty, p_one, p_ready, p_lvld, p_flush;

  function automatic void model_reset();
    m_credit[0] = LC;
    m_credit[1] = LC;
    m_rr = 0;
    m_ord.delete();
    lq0.delete();
    lq1.delete();
  endfunction

  function automatic bit lane_ready(int l);
    if (l == 0) return (lq0.size() > 0) && (lq0[0] <= cyc);
    return (lq1.size() > 0) && (lq1[0] <= cyc);
  endfunction

  function automatic void lane_push(int l, int t);
    int tt;
    tt = t;
    if (l == 0) begin
      if (lq0.size() > 0 && tt < lq0[$]) tt = lq0[$];
      lq0.push_back(tt);
    end else begin
      if (lq1.size() > 0 && tt < lq1[$]) tt = lq1[$];
      lq1.push_back(tt);
    end
  endfunction

  function automatic void lane_pop(int l);
    if (l == 0) void'(lq0.pop_front());
    else        void'(lq1.pop_front());
  endfunction

  // Present lane results for this cycle and let combinational outputs settle.
  task automatic settle();
    io.lane_res_vld = {gate[1] && lane_ready(1), gate[0] && lane_ready(0)};
    #1;
  endtask

  // Compare all outputs with the model, then advance one clock and update the model.
  task automatic advance();
    logic [1:0] e_pop, e_iv, e_src, e_rv, e_sel, e_ack;
    int occ, t0, t1, o0, o1;
    bit f0, f1;
    e_pop = '0; e_iv = '0; e_src = '0; e_rv = '0; e_sel = '0; e_ack = '0;
    f0 = 0; f1 = 0; t0 = 0; t1 = 0; o0 = 0; o1 = 0;
    occ = rst ? 0 : m_ord.size();
    if (!rst && !flush) begin
      if (!io.rs_fifo_empty && (m_credit[0] > 0 || m_credit[1] > 0) && (OD - occ) >= 1) begin
        t0 = (m_credit[m_rr] > 0) ? m_rr : 1 - m_rr;
        t1 = 1 - t0;
        e_pop[0] = 1'b1;
        e_iv[t0] = 1'b1;
        if (!io.rs_fifo_1left_to_empty && m_credit[t1] > 0 && (OD - occ) >= 2) begin
          e_pop[1] = 1'b1;
          e_iv[t1] = 1'b1;
          e_src[t1] = 1'b1;
        end
      end
      if (occ >= 1) begin
        o0 = m_ord[0];
        if (io.lane_res_vld[o0]) begin
          e_rv[0] = 1'b1;
          e_sel[0] = o0[0];
          f0 = io.rob_ready[0];
        end
      end
      if (f0 && occ >= 2) begin
        o1 = m_ord[1];
        if (o1 != o0 && io.lane_res_vld[o1]) begin
          e_rv[1] = 1'b1;
          e_sel[1] = o1[0];
          f1 = io.rob_ready[1];
        end
      end
      if (f0) e_ack[o0] = 1'b1;
      if (f1) e_ack[o1] = 1'b1;
    end
    check("pop",      io.ex2rs_fifo_pop, e_pop);
    check("issue_vld", io.lane_issue_vld, e_iv);
    check("issue_src", io.lane_issue_src, e_src);
    check("rob_vld",  io.rob_vld, e_rv);
    check("rob_sel",  io.rob_lane_sel, e_sel);
    check("res_ack",  io.lane_res_ack, e_ack);
    check("inflight", io.inflight_cnt, occ);
    @(posedge clk);
    cyc++;
    if (rst || flush) begin
      model_reset();
    end else begin
      if (f0) begin m_credit[o0]++; lane_pop(o0); void'(m_ord.pop_front()); end
      if (f1) begin m_credit[o1]++; lane_pop(o1); void'(m_ord.pop_front()); end
      if (e_pop[0]) begin
        m_ord.push_back(t0); m_credit[t0]--;
        lane_push(t0, cyc - 1 + $urandom_range(1, lat_max));
      end
      if (e_pop[1]) begin
        m_ord.push_back(t1); m_credit[t1]--;
        lane_push(t1, cyc - 1 + $urandom_range(1, lat_max));
      end
      if (e_pop == 2'b01) m_rr = 1 - m_rr;
    end
    #1;
  endtask

  task automatic cycle();
    settle();
    advance();
  endtask

  task automatic set_in(bit empty, bit one, logic [1:0] rdy, bit g0, bit g1);
    io.rs_fifo_empty = empty;
    io.rs_fifo_1left_to_empty = one;
    io.rob_ready = rdy;
    gate[0] = g0;
    gate[1] = g1;
  endtask

  task automatic drive_rand();
    io.rs_fifo_empty = ($urandom_range(0, 99) < p_empty);
    io.rs_fifo_1left_to_empty = !io.rs_fifo_empty && ($urandom_range(0, 99) < p_one);
    io.rob_ready[0] = ($urandom_range(0, 99) < p_ready);
    io.rob_ready[1] = ($urandom_range(0, 99) < p_ready);
    gate[0] = ($urandom_range(0, 99) < p_lvld);
    gate[1] = ($urandom_range(0, 99) < p_lvld);
    flush = ($urandom_range(0, 99) < p_flush);
  endtask

  initial begin
    model_reset();
    set_in(1, 0, 2'b00, 0, 0);
    io.lane_res_vld = '0;
    #1;
    // Reset state
    cycle();
    check("rst_inflight", io.inflight_cnt, 0);
    cycle();
    rst = 1'b0;

    // Single uop: lane 0 first, then rr moves to lane 1
    set_in(0, 1, 2'b00, 0, 0);
    settle();
    check("single_pop", io.ex2rs_fifo_pop, 2'b01);
    check("single_iss", io.lane_issue_vld, 2'b01);
    advance();
    check("single_occ", io.inflight_cnt, 1);
    settle();
    check("single_rr1", io.lane_issue_vld, 2'b10);
    advance();
    flush = 1'b1; cycle(); flush = 1'b0;

    // ROB stalled under continuous pairs: six in flight, then in-order drain
    lat_max = 1;
    set_in(0, 0, 2'b00, 1, 1);
    repeat (6) cycle();
    check("stall_occ", io.inflight_cnt, 6);
    settle();
    check("stall_pop", io.ex2rs_fifo_pop, 2'b00);
    advance();
    set_in(1, 0, 2'b11, 1, 1);
    repeat (6) cycle();
    check("drain_occ", io.inflight_cnt, 0);

    // Younger lane 1 result ready before older lane 0
    flush = 1'b1; cycle(); flush = 1'b0;
    set_in(0, 0, 2'b11, 0, 0);
    cycle();
    set_in(1, 0, 2'b11, 0, 1);
    repeat (3) begin
      settle();
      check("ooo_hold_vld", io.rob_vld, 2'b00);
      check("ooo_hold_ack", io.lane_res_ack, 2'b00);
      advance();
    end
    set_in(1, 0, 2'b11, 1, 1);
    settle();
    check("ooo_both_vld", io.rob_vld, 2'b11);
    check("ooo_both_sel", io.rob_lane_sel, 2'b10);
    check("ooo_both_ack", io.lane_res_ack, 2'b11);
    advance();

    // Flush with five in flight
    flush = 1'b1; cycle(); flush = 1'b0;
    set_in(0, 0, 2'b00, 0, 0);
    repeat (2) cycle();
    set_in(0, 1, 2'b00, 0, 0);
    cycle();
    check("pre_flush_occ", io.inflight_cnt, 5);
    set_in(0, 0, 2'b11, 1, 1);
    flush = 1'b1;
    settle();
    check("flush_pop", io.ex2rs_fifo_pop, 2'b00);
    check("flush_iss", io.lane_issue_vld, 2'b00);
    check("flush_rob", io.rob_vld, 2'b00);
    check("flush_ack", io.lane_res_ack, 2'b00);
    advance();
    flush = 1'b0;
    check("flush_occ", io.inflight_cnt, 0);
    set_in(0, 0, 2'b00, 0, 0);
    settle();
    check("flush_full_cr", io.ex2rs_fifo_pop, 2'b11);
    advance();

    // Asynchronous reset in the middle of a burst
    lat_max = 3;
    set_in(0, 0, 2'b11, 1, 0);
    repeat (3) cycle();
    rst = 1'b1;
    #1;
    check("arst_occ", io.inflight_cnt, 0);
    check("arst_pop", io.ex2rs_fifo_pop, 2'b00);
    cycle();
    rst = 1'b0;

    // Randomized phases with varying pressure
    for (int ph = 0; ph < 15; ph++) begin
      p_empty = $urandom_range(0, 60);
      p_one   = $urandom_range(0, 50);
      p_ready = $urandom_range(30, 100);
      p_lvld  = $urandom_range(40, 100);
      p_flush = (ph % 3 == 2) ? 2 : 0;
      lat_max = $urandom_range(1, 4);
      for (int c = 0; c < 200; c++) begin
        drive_rand();
        cycle();
      end
    end
    flush = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
